// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter with a valid/ready word input,
// internal baud divider, even/odd/no parity and one or two stop bits.
// Define UART_TX_BREAK_EN to add a tx_break input that holds the line low
// (break condition) while the transmitter is idle.
module uart_tx_param #(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY_MODE  = 1,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
`ifdef UART_TX_BREAK_EN
  input  logic                 tx_break,
`endif
  output logic                 tx_ready,
  output logic                 tx_out,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int unsigned BAUD_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BIT_W      = $clog2(DATA_BITS + 1);
  localparam bit          HAS_PARITY = (PARITY_MODE != 0);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  // Reject illegal configurations at elaboration
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_param: DATA_BITS must be in 5..9");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("uart_tx_param: CLKS_PER_BIT must be >= 2");
  end
  if (PARITY_MODE > 2) begin : g_bad_parity_mode
    $error("uart_tx_param: PARITY_MODE must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } state_e;

  state_e                state_q, state_d;
  logic [BAUD_W-1:0]     baud_q, baud_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic                  parity_q, parity_d;
  logic                  tx_out_q, tx_out_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  ready_q, ready_d;
  logic                  baud_tick;

  assign baud_tick = (baud_q == BAUD_LAST);

  // State and datapath registers; reset forces the line idle-high at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      tx_out_q <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      tx_out_q <= tx_out_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
    end
  end

  // Next-state, bit sequencing and registered output values
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    tx_out_d = tx_out_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    if (state_q != ST_IDLE && state_q != ST_BREAK) begin
      baud_d = baud_tick ? '0 : BAUD_W'(baud_q + 1'b1);
    end

    unique case (state_q)
      ST_IDLE: begin
        if (tx_valid) begin
          state_d  = ST_START;
          shift_d  = tx_data;
          parity_d = (PARITY_MODE == 2) ? ~(^tx_data) : (^tx_data);
          tx_out_d = 1'b0;
          busy_d   = 1'b1;
          baud_d   = '0;
          bit_d    = '0;
        end
`ifdef UART_TX_BREAK_EN
        else if (tx_break) begin
          state_d  = ST_BREAK;
          tx_out_d = 1'b0;
          busy_d   = 1'b1;
        end
`endif
      end
      ST_START: begin
        if (baud_tick) begin
          state_d  = ST_DATA;
          tx_out_d = shift_q[0];
          bit_d    = '0;
        end
      end
      ST_DATA: begin
        if (baud_tick) begin
          if (bit_q == DATA_LAST) begin
            bit_d = '0;
            if (HAS_PARITY) begin
              state_d  = ST_PARITY;
              tx_out_d = parity_q;
            end else begin
              state_d  = ST_STOP;
              tx_out_d = 1'b1;
            end
          end else begin
            bit_d    = BIT_W'(bit_q + 1'b1);
            shift_d  = shift_q >> 1;
            tx_out_d = shift_q[1];
          end
        end
      end
      ST_PARITY: begin
        if (baud_tick) begin
          state_d  = ST_STOP;
          tx_out_d = 1'b1;
          bit_d    = '0;
        end
      end
      ST_STOP: begin
        if (baud_tick) begin
          if (bit_q == STOP_LAST) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            bit_d   = '0;
          end else begin
            bit_d = BIT_W'(bit_q + 1'b1);
          end
        end
      end
`ifdef UART_TX_BREAK_EN
      ST_BREAK: begin
        if (!tx_break) begin
          state_d  = ST_IDLE;
          tx_out_d = 1'b1;
          busy_d   = 1'b0;
        end
      end
`endif
      default: begin
        state_d  = ST_IDLE;
        tx_out_d = 1'b1;
        busy_d   = 1'b0;
      end
    endcase

    ready_d = (state_d == ST_IDLE);
  end

  assign tx_ready   = ready_q;
  assign tx_out     = tx_out_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Scoreboard bench for uart_tx_param: three instances (even parity, odd
// parity, no parity with two stop bits) share clock and reset. Words are
// queued when offered; a cycle-accurate monitor pops them as frames start.
module tb_uart_tx_param;

  localparam int unsigned NDUT = 3;
  localparam int unsigned CPB  = 4;
  localparam int unsigned DW   = 8;

  logic clk = 1'b0;
  logic rst_n;

  logic          tx_valid_a   [NDUT];
  logic [DW-1:0] tx_data_a    [NDUT];
  logic          tx_ready_a   [NDUT];
  logic          tx_out_a     [NDUT];
  logic          busy_a       [NDUT];
  logic          frame_done_a [NDUT];
`ifdef UART_TX_BREAK_EN
  logic          tx_break_a   [NDUT];
`endif

  logic [DW-1:0] exp_q [NDUT][$];

  int        mon_phase [NDUT] = '{default: 0};
  int        mon_cyc   [NDUT] = '{default: 0};
  int        mon_gap   [NDUT] = '{default: 0};
  int        last_gap  [NDUT] = '{default: 0};
  logic      mon_dchk  [NDUT] = '{default: 1'b0};
  logic      mon_obs   [NDUT] = '{default: 1'b0};
  logic      mon_hs    [NDUT] = '{default: 1'b0};
  logic [15:0] mon_bits [NDUT] = '{default: 16'h0};

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY_MODE(1), .STOP_BITS(1)) u_even (
    .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid_a[0]), .tx_data(tx_data_a[0]),
`ifdef UART_TX_BREAK_EN
    .tx_break(tx_break_a[0]),
`endif
    .tx_ready(tx_ready_a[0]), .tx_out(tx_out_a[0]), .busy(busy_a[0]),
    .frame_done(frame_done_a[0]));

  uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY_MODE(2), .STOP_BITS(1)) u_odd (
    .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid_a[1]), .tx_data(tx_data_a[1]),
`ifdef UART_TX_BREAK_EN
    .tx_break(tx_break_a[1]),
`endif
    .tx_ready(tx_ready_a[1]), .tx_out(tx_out_a[1]), .busy(busy_a[1]),
    .frame_done(frame_done_a[1]));

  uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY_MODE(0), .STOP_BITS(2)) u_none (
    .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid_a[2]), .tx_data(tx_data_a[2]),
`ifdef UART_TX_BREAK_EN
    .tx_break(tx_break_a[2]),
`endif
    .tx_ready(tx_ready_a[2]), .tx_out(tx_out_a[2]), .busy(busy_a[2]),
    .frame_done(frame_done_a[2]));

  // Per-instance configuration as seen by the model
  function automatic int pmode(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 2 : 0);
  endfunction

  function automatic int nstop(input int k);
    return (k == 2) ? 2 : 1;
  endfunction

  function automatic int frame_len(input int k);
    return (1 + DW + ((pmode(k) != 0) ? 1 : 0) + nstop(k)) * CPB;
  endfunction

  // Expected serial bit sequence, index 0 = start bit
  function automatic logic [15:0] frame_bits(input int k, input logic [DW-1:0] w);
    logic [15:0] b;
    int idx;
    b = 16'h0;
    idx = 1;
    for (int i = 0; i < DW; i++) begin
      b[idx] = w[i];
      idx++;
    end
    if (pmode(k) == 1) begin
      b[idx] = ^w;
      idx++;
    end else if (pmode(k) == 2) begin
      b[idx] = ~(^w);
      idx++;
    end
    for (int i = 0; i < nstop(k); i++) begin
      b[idx] = 1'b1;
      idx++;
    end
    return b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One monitor step per instance per falling edge
  task automatic mon_step(input int k);
    int   len;
    int   bi;
    logic eb;
    logic exempt;
    len = frame_len(k);
    if (!rst_n) begin
      mon_phase[k] = 0;
      mon_gap[k]   = 0;
      mon_dchk[k]  = 1'b0;
      return;
    end
`ifdef UART_TX_BREAK_EN
    exempt = busy_a[k] && !tx_ready_a[k];
`else
    exempt = 1'b0;
`endif
    if (mon_phase[k] == 1 && mon_cyc[k] >= len) begin
      chk($sformatf("d%0d_frame_end", k),
          {28'h0, frame_done_a[k], busy_a[k], tx_ready_a[k], tx_out_a[k]}, 32'hB);
      mon_phase[k] = 0;
      mon_gap[k]   = 1;
      mon_dchk[k]  = 1'b1;
    end else if (mon_phase[k] == 0) begin
      if (mon_dchk[k]) begin
        chk($sformatf("d%0d_done_pulse", k), frame_done_a[k], 1'b0);
        mon_dchk[k] = 1'b0;
      end else if (frame_done_a[k]) begin
        chk($sformatf("d%0d_stray_done", k), frame_done_a[k], 1'b0);
      end
      if (tx_out_a[k] == 1'b0) begin
        if (exp_q[k].size() > 0) begin
          mon_bits[k]  = frame_bits(k, exp_q[k].pop_front());
          last_gap[k]  = mon_gap[k];
          mon_phase[k] = 1;
          mon_cyc[k]   = 0;
          mon_hs[k]    = 1'b1;
        end else if (!exempt) begin
          chk($sformatf("d%0d_spurious_low", k), tx_out_a[k], 1'b1);
        end
      end else begin
        mon_gap[k]++;
      end
    end
    if (mon_phase[k] == 1 && mon_cyc[k] < len) begin
      bi = mon_cyc[k] / CPB;
      eb = mon_bits[k][bi];
      if (mon_cyc[k] % CPB == 0) mon_obs[k] = eb;
      if (tx_out_a[k] !== eb) mon_obs[k] = tx_out_a[k];
      if (busy_a[k] !== 1'b1 || tx_ready_a[k] !== 1'b0 || frame_done_a[k] !== 1'b0)
        mon_hs[k] = 1'b0;
      if (mon_cyc[k] % CPB == CPB - 1)
        chk($sformatf("d%0d_bit%0d", k, bi), mon_obs[k], eb);
      if (mon_cyc[k] == len - 1)
        chk($sformatf("d%0d_busy_ready_in_frame", k), mon_hs[k], 1'b1);
      mon_cyc[k]++;
    end
  endtask

  // Output monitor, sampling away from the rising edge
  always @(negedge clk) begin
    for (int k = 0; k < NDUT; k++) mon_step(k);
  end

  // Offer a word, wait for tx_ready, queue it, then scramble tx_data
  task automatic send(input int k, input logic [DW-1:0] w, input bit hold);
    int n;
    n = 0;
    tx_valid_a[k] = 1'b1;
    tx_data_a[k]  = w;
    while (!tx_ready_a[k] && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("d%0d_ready_wait", k), tx_ready_a[k], 1'b1);
    exp_q[k].push_back(w);
    @(negedge clk);
    tx_data_a[k] = ~w;
    if (!hold) tx_valid_a[k] = 1'b0;
  endtask

  // Wait until the queued words for instance k have all been framed
  task automatic wait_idle(input int k);
    int n;
    n = 0;
    while ((mon_phase[k] != 0 || exp_q[k].size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("d%0d_frame_completes", k), (n < 500), 1'b1);
    @(negedge clk);
  endtask

  initial begin
    int hi;
`ifdef UART_TX_BREAK_EN
    int low;
`endif
    for (int k = 0; k < NDUT; k++) begin
      tx_valid_a[k] = 1'b0;
      tx_data_a[k]  = '0;
`ifdef UART_TX_BREAK_EN
      tx_break_a[k] = 1'b0;
`endif
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      chk($sformatf("d%0d_rst_tx_out", k), tx_out_a[k], 1'b1);
      chk($sformatf("d%0d_rst_busy", k), busy_a[k], 1'b0);
      chk($sformatf("d%0d_rst_done", k), frame_done_a[k], 1'b0);
      chk($sformatf("d%0d_rst_ready", k), tx_ready_a[k], 1'b1);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    send(0, 8'hA5, 1'b0); wait_idle(0);
    send(1, 8'h07, 1'b0); wait_idle(1);
    send(2, 8'h00, 1'b0); wait_idle(2);
    send(0, 8'h1F, 1'b0); wait_idle(0);
    send(1, 8'hFF, 1'b0); wait_idle(1);
    send(2, 8'h5A, 1'b0); wait_idle(2);

    // Back-to-back with tx_valid held and tx_data changing mid-frame
    send(0, 8'h3C, 1'b1);
    send(0, 8'hC3, 1'b0);
    wait_idle(0);
    chk("d0_b2b_idle_gap", last_gap[0], 1);

    // Idle line with no valid stays high
    hi = 0;
    repeat (20) begin
      @(negedge clk);
      for (int k = 0; k < NDUT; k++) if (tx_out_a[k] === 1'b1) hi++;
    end
    chk("idle_line_high", hi, 60);

    // Reset in the middle of the data bits (low nibble of 0xF0 is zero)
    send(2, 8'hF0, 1'b0);
    repeat (16) @(negedge clk);
    chk("d2_mid_data_line_low", tx_out_a[2], 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("d2_rst_async_tx_out", tx_out_a[2], 1'b1);
    chk("d2_rst_async_busy", busy_a[2], 1'b0);
    chk("d2_rst_async_done", frame_done_a[2], 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    send(2, 8'h81, 1'b0); wait_idle(2);

`ifdef UART_TX_BREAK_EN
    // Break held for 20 cycles while idle
    low = 0;
    tx_break_a[0] = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (tx_out_a[0] === 1'b0 && tx_ready_a[0] === 1'b0 && busy_a[0] === 1'b1) low++;
    end
    tx_break_a[0] = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (tx_out_a[0] === 1'b0 && tx_ready_a[0] === 1'b0 && busy_a[0] === 1'b1) low++;
    end
    chk("d0_break_low_cycles", low, 20);
    chk("d0_break_release_high", tx_out_a[0], 1'b1);

    // Break raised mid-frame: frame completes, then the line goes low
    send(0, 8'h96, 1'b0);
    repeat (8) @(negedge clk);
    tx_break_a[0] = 1'b1;
    wait_idle(0);
    repeat (3) @(negedge clk);
    chk("d0_break_after_frame_line", tx_out_a[0], 1'b0);
    chk("d0_break_after_frame_ready", tx_ready_a[0], 1'b0);
    tx_break_a[0] = 1'b0;
    @(negedge clk);
    chk("d0_break_end_line", tx_out_a[0], 1'b1);
`endif

    for (int k = 0; k < NDUT; k++) wait_idle(k);
    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Bound on total run time
  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
